apb_slave_mem: RTL

//   APB4 completer sitting directly downstream of the APB bus interface (slave modport).

---
 rtl/apb_slave_mem_if.sv | 24 ++
 rtl/apb_slave_mem.sv | 125 ++++++++++++
 2 files changed

// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between a requester and the apb_slave_mem completer.
// Clock and reset stay outside so the same bundle can be shared by several completers.
interface apb_slave_mem_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a word-addressed register bank with byte strobes,
// a fixed number of wait states per access and PSLVERR on bad or unprivileged accesses.
module apb_slave_mem #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter bit          PRIV_WRITE  = 1'b1
) (
    input logic          PCLK,
    input logic          PRESETn,
    apb_slave_mem_if.slave apb
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] LO        = {1'b0, BASE_ADDR};
    localparam logic [32:0] HI        = LO + 33'(DEPTH * 4);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_ready, w_ready_nxt;
    logic          r_slverr, w_slverr_nxt;
    logic [31:0]   r_rdata, w_rdata_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic          r_write, w_write_nxt;
    logic          r_err, w_err_nxt;
    logic          w_commit;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_setup_idx;
    logic          w_in_range;
    logic          w_setup_err;
    logic          w_unused_prot;

    assign w_setup_idx   = AW'((apb.PADDR - BASE_ADDR) >> 2);
    assign w_in_range    = ({1'b0, apb.PADDR} >= LO) && ({1'b0, apb.PADDR} < HI);
    // PENABLE already high in the first selected cycle is a protocol violation: force an error.
    assign w_setup_err   = (apb.PADDR[1:0] != 2'b00) || !w_in_range
                         || (PRIV_WRITE && apb.PWRITE && !apb.PPROT[0]) || apb.PENABLE;
    assign w_unused_prot = ^apb.PPROT[2:1];

    assign apb.PREADY  = r_ready;
    assign apb.PSLVERR = r_slverr;
    assign apb.PRDATA  = r_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_write_nxt  = r_write;
        w_err_nxt    = r_err;
        w_ready_nxt  = 1'b0;
        w_slverr_nxt = 1'b0;
        w_rdata_nxt  = 32'h0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (apb.PSEL) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = WAIT_INIT;
                    w_idx_nxt   = w_setup_idx;
                    w_write_nxt = apb.PWRITE;
                    w_err_nxt   = w_setup_err;
                    if (WAIT_CYCLES == 0) begin
                        w_ready_nxt  = 1'b1;
                        w_slverr_nxt = w_setup_err;
                        w_rdata_nxt  = (!w_setup_err && !apb.PWRITE) ? r_mem[w_setup_idx] : 32'h0;
                    end
                end
            end
            ACCESS: begin
                if (!apb.PSEL) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_ready) begin
                    w_state_nxt = IDLE;
                    w_commit    = r_write && !r_err;
                end else if (apb.PENABLE) begin
                    // Outputs are registered, so completion is flagged one edge ahead of cnt reaching 0.
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_ready_nxt  = 1'b1;
                        w_slverr_nxt = r_err;
                        w_rdata_nxt  = (!r_err && !r_write) ? r_mem[r_idx] : 32'h0;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= 32'h0;
            r_idx    <= '0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
            r_rdata  <= w_rdata_nxt;
            r_idx    <= w_idx_nxt;
            r_write  <= w_write_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Write data and strobes are taken live from the bus in the completion cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
        end else if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (apb.PSTRB[b]) r_mem[r_idx][8*b +: 8] <= apb.PWDATA[8*b +: 8];
            end
        end
    end
endmodule
